// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan decoder: segment patterns
// (p = ~seg_h, bit0=a .. bit6=g), digit count, FSM states and decode payload.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned DIGIT_W    = 3;
  localparam int unsigned SAMPLE_W   = NUM_DIGITS + 1 + SEG_W;
  localparam int unsigned FRAME_W    = NUM_DIGITS * NIB_W;
  localparam int unsigned CNT_W      = 8;

  localparam logic [SEG_W-1:0] PAT_0     = 7'h3F;
  localparam logic [SEG_W-1:0] PAT_1     = 7'h06;
  localparam logic [SEG_W-1:0] PAT_2     = 7'h5B;
  localparam logic [SEG_W-1:0] PAT_3     = 7'h4F;
  localparam logic [SEG_W-1:0] PAT_4     = 7'h66;
  localparam logic [SEG_W-1:0] PAT_5     = 7'h6D;
  localparam logic [SEG_W-1:0] PAT_6     = 7'h7D;
  localparam logic [SEG_W-1:0] PAT_7     = 7'h07;
  localparam logic [SEG_W-1:0] PAT_8     = 7'h7F;
  localparam logic [SEG_W-1:0] PAT_9     = 7'h6F;
  localparam logic [SEG_W-1:0] PAT_A     = 7'h77;
  localparam logic [SEG_W-1:0] PAT_B     = 7'h7C;
  localparam logic [SEG_W-1:0] PAT_C     = 7'h39;
  localparam logic [SEG_W-1:0] PAT_D     = 7'h5E;
  localparam logic [SEG_W-1:0] PAT_E     = 7'h79;
  localparam logic [SEG_W-1:0] PAT_F     = 7'h71;
  localparam logic [SEG_W-1:0] PAT_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2
  } state_t;

  // Decoded digit: nibble value, pattern recognised, all segments off
  typedef struct packed {
    logic [NIB_W-1:0] nibble;
    logic             valid;
    logic             blank;
  } dec_t;

endpackage

// File: rtl/seg7_pat_decode.sv
// Combinational segment-pattern decoder.
//   p      : lit segments (active-high), bit0=a .. bit6=g
//   dec_c  : {nibble, valid, blank}; blank counts as valid, unknown -> nibble 0
module seg7_pat_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] p,
  output dec_t             dec_c
);

  always_comb begin
    dec_c.nibble = '0;
    dec_c.valid  = 1'b1;
    dec_c.blank  = 1'b0;
    case (p)
      PAT_0:     dec_c.nibble = 4'h0;
      PAT_1:     dec_c.nibble = 4'h1;
      PAT_2:     dec_c.nibble = 4'h2;
      PAT_3:     dec_c.nibble = 4'h3;
      PAT_4:     dec_c.nibble = 4'h4;
      PAT_5:     dec_c.nibble = 4'h5;
      PAT_6:     dec_c.nibble = 4'h6;
      PAT_7:     dec_c.nibble = 4'h7;
      PAT_8:     dec_c.nibble = 4'h8;
      PAT_9:     dec_c.nibble = 4'h9;
      PAT_A:     dec_c.nibble = 4'hA;
      PAT_B:     dec_c.nibble = 4'hB;
      PAT_C:     dec_c.nibble = 4'hC;
      PAT_D:     dec_c.nibble = 4'hD;
      PAT_E:     dec_c.nibble = 4'hE;
      PAT_F:     dec_c.nibble = 4'hF;
      PAT_BLANK: dec_c.blank  = 1'b1;
      default:   dec_c.valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers multiplexed 8-digit seven-segment display content into frames.
//   clk, rst     : clock, synchronous active-high reset
//   seg_h        : active-low segments (bit0=a .. bit6=g)
//   seg_dp       : active-low decimal point
//   seg_an       : active-low digit enables
//   frame_value  : assembled nibbles, digit i at [4i+3:4i]
//   frame_dp     : decimal point lit per digit
//   frame_blank  : digit had all segments off
//   frame_err    : frame contained an undecodable pattern
//   frame_valid  : one-cycle pulse when frame_* update
//   drop_cnt     : saturating count of frames aborted by out-of-order digits
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEG_W-1:0]      seg_h,
  input  logic                  seg_dp,
  input  logic [NUM_DIGITS-1:0] seg_an,
  output logic [FRAME_W-1:0]    frame_value,
  output logic [NUM_DIGITS-1:0] frame_dp,
  output logic [NUM_DIGITS-1:0] frame_blank,
  output logic                  frame_err,
  output logic                  frame_valid,
  output logic [CNT_W-1:0]      drop_cnt
);

  localparam logic [CNT_W-1:0]   STAB_MAX  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STAB_PRE  = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [DIGIT_W-1:0] LAST_DIG  = DIGIT_W'(NUM_DIGITS - 1);

  logic [SAMPLE_W-1:0]   sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0]      stab_q;
  logic                  same_c, one_hot_c, capture_c;
  logic [NUM_DIGITS-1:0] an_sel_c;
  logic [DIGIT_W-1:0]    digit_c;
  dec_t                  dec_c;

  state_t                state_q, state_d;
  logic [DIGIT_W-1:0]    expect_q, expect_d;
  logic [FRAME_W-1:0]    val_q, val_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      drop_d;
  logic                  start_c, store_c, load_c;

  // Two-flop synchronizer, previous-sample register and stability counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      stab_q  <= '0;
    end else begin
      sync1_q <= {seg_an, seg_dp, seg_h};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (!same_c)              stab_q <= '0;
      else if (stab_q != STAB_MAX) stab_q <= stab_q + CNT_W'(1);
    end
  end

  assign same_c    = (sync2_q == prev_q);
  assign an_sel_c  = ~sync2_q[SAMPLE_W-1 -: NUM_DIGITS];
  assign one_hot_c = (an_sel_c != '0) && ((an_sel_c & (an_sel_c - NUM_DIGITS'(1))) == '0);
  // Fires in the cycle the counter steps onto its saturation value, so once per window
  assign capture_c = same_c && (stab_q == STAB_PRE) && one_hot_c;

  // Selected digit index from the one-hot enable
  always_comb begin
    digit_c = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_sel_c[i]) digit_c = DIGIT_W'(i);
    end
  end

  seg7_pat_decode u_dec (
    .p     (~sync2_q[SEG_W-1:0]),
    .dec_c (dec_c)
  );

  // Next-state, accumulator and counter logic
  always_comb begin
    state_d  = state_q;
    expect_d = expect_q;
    val_d    = val_q;
    dp_d     = dp_q;
    blank_d  = blank_q;
    err_d    = err_q;
    drop_d   = drop_cnt;
    start_c  = 1'b0;
    store_c  = 1'b0;
    load_c   = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        if (capture_c) begin
          if (digit_c == expect_q) begin
            store_c = 1'b1;
            if (expect_q == LAST_DIG) begin
              state_d = ST_EMIT;
              load_c  = 1'b1;
            end else begin
              expect_d = expect_q + DIGIT_W'(1);
            end
          end else begin
            if (drop_cnt != '1) drop_d = drop_cnt + CNT_W'(1);
            if (digit_c == '0) begin
              start_c  = 1'b1;
              expect_d = DIGIT_W'(1);
            end else begin
              state_d = ST_SYNC;
            end
          end
        end
      end
      // SYNC and the single EMIT cycle share the same capture handling
      default: begin
        state_d = ST_SYNC;
        if (capture_c && digit_c == '0) begin
          start_c  = 1'b1;
          expect_d = DIGIT_W'(1);
          state_d  = ST_COLLECT;
        end
      end
    endcase

    if (start_c) begin
      val_d   = '0;
      dp_d    = '0;
      blank_d = '0;
      err_d   = 1'b0;
    end
    if (start_c || store_c) begin
      val_d[{digit_c, 2'b00} +: NIB_W] = dec_c.nibble;
      dp_d[digit_c]    = ~sync2_q[SEG_W];
      blank_d[digit_c] = dec_c.blank;
      err_d            = err_d | ~dec_c.valid;
    end
  end

  // State, accumulators and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SYNC;
      expect_q    <= '0;
      val_q       <= '0;
      dp_q        <= '0;
      blank_q     <= '0;
      err_q       <= 1'b0;
      drop_cnt    <= '0;
      frame_value <= '0;
      frame_dp    <= '0;
      frame_blank <= '0;
      frame_err   <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      expect_q    <= expect_d;
      val_q       <= val_d;
      dp_q        <= dp_d;
      blank_q     <= blank_d;
      err_q       <= err_d;
      drop_cnt    <= drop_d;
      frame_valid <= load_c;
      if (load_c) begin
        frame_value <= val_d;
        frame_dp    <= dp_d;
        frame_blank <= blank_d;
        frame_err   <= err_d;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: stimulus pushes hand-computed frames,
// a monitor pops and compares on every frame_valid pulse.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_h;
  logic        seg_dp;
  logic [7:0]  seg_an;
  logic [31:0] frame_value;
  logic [7:0]  frame_dp;
  logic [7:0]  frame_blank;
  logic        frame_err;
  logic        frame_valid;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_h       (seg_h),
    .seg_dp      (seg_dp),
    .seg_an      (seg_an),
    .frame_value (frame_value),
    .frame_dp    (frame_dp),
    .frame_blank (frame_blank),
    .frame_err   (frame_err),
    .frame_valid (frame_valid),
    .drop_cnt    (drop_cnt)
  );

  typedef struct packed {
    logic [31:0] v;
    logic [7:0]  dp;
    logic [7:0]  bl;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   fails  = 0;
  int   frames = 0;

  function automatic logic [6:0] pat(input logic [3:0] n);
    case (n)
      4'h0: pat = 7'h3F;  4'h1: pat = 7'h06;  4'h2: pat = 7'h5B;  4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;  4'h5: pat = 7'h6D;  4'h6: pat = 7'h7D;  4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;  4'h9: pat = 7'h6F;  4'hA: pat = 7'h77;  4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;  4'hD: pat = 7'h5E;  4'hE: pat = 7'h79;  default: pat = 7'h71;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    seg_an = 8'hFF;
    seg_h  = 7'h7F;
    seg_dp = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic show(input int d, input logic [6:0] p, input logic dp, input int hold);
    seg_an = ~(8'd1 << d);
    seg_h  = ~p;
    seg_dp = ~dp;
    repeat (hold) @(negedge clk);
  endtask

  // Full scan of digits 0..7; blm forces a blank digit, bad digit shows segment a only
  task automatic scan(input logic [31:0] vals, input logic [7:0] dpm, input logic [7:0] blm,
                      input int bad, input int hold);
    for (int i = 0; i < 8; i++) begin
      logic [3:0] n;
      logic [6:0] p;
      n = vals[4*i +: 4];
      if (blm[i])        p = 7'h00;
      else if (i == bad) p = 7'h01;
      else               p = pat(n);
      show(i, p, dpm[i], hold);
    end
    idle(4);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d frames still pending, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: compare each emitted frame against the scoreboard head
  initial begin
    exp_t e;
    logic chk_next;
    chk_next = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_next) check("valid_one_cycle", 32'(frame_valid), 32'd0);
      chk_next = 1'b0;
      if (rst === 1'b0 && frame_valid === 1'b1) begin
        frames++;
        chk_next = 1'b1;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: got frame_value 0x%0h, want no frame", frame_value);
        end else begin
          e = exp_q.pop_front();
          check("frame_value", frame_value, e.v);
          check("frame_dp", 32'(frame_dp), 32'(e.dp));
          check("frame_blank", 32'(frame_blank), 32'(e.bl));
          check("frame_err", 32'(frame_err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int f0;
    rst = 1'b1;
    idle(3);
    check("rst_value", frame_value, 32'd0);
    check("rst_dp", 32'(frame_dp), 32'd0);
    check("rst_blank", 32'(frame_blank), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_valid", 32'(frame_valid), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    idle(4);

    // Clean scan 1..8
    exp_q.push_back('{v: 32'h87654321, dp: 8'h00, bl: 8'h00, err: 1'b0});
    scan(32'h87654321, 8'h00, 8'h00, -1, 8);
    drain("clean_frame");
    idle(5);
    check("hold_value", frame_value, 32'h87654321);
    check("hold_valid_low", 32'(frame_valid), 32'd0);

    // Undecodable pattern on digit 3
    exp_q.push_back('{v: 32'h87650321, dp: 8'h00, bl: 8'h00, err: 1'b1});
    scan(32'h87654321, 8'h00, 8'h00, 3, 8);
    drain("err_frame");

    // Blank digit 5, decimal point on digit 2
    exp_q.push_back('{v: 32'h87054321, dp: 8'h04, bl: 8'h20, err: 1'b0});
    scan(32'h87654321, 8'h04, 8'h20, -1, 8);
    drain("blank_dp_frame");

    // Out-of-order 0,1,2,5 aborts the frame
    f0 = frames;
    show(0, pat(4'h1), 1'b0, 8);
    show(1, pat(4'h2), 1'b0, 8);
    show(2, pat(4'h3), 1'b0, 8);
    show(5, pat(4'h6), 1'b0, 8);
    idle(6);
    check("order_drop", 32'(drop_cnt), 32'd1);
    check("order_no_frame", 32'(frames), 32'(f0));
    exp_q.push_back('{v: 32'h87654321, dp: 8'h00, bl: 8'h00, err: 1'b0});
    scan(32'h87654321, 8'h00, 8'h00, -1, 8);
    drain("recover_frame");
    check("recover_drop", 32'(drop_cnt), 32'd1);

    // Too-short hold and multi-select enable give no captures
    f0 = frames;
    scan(32'h87654321, 8'h00, 8'h00, -1, 2);
    seg_an = 8'hFC;
    seg_h  = ~pat(4'h1);
    seg_dp = 1'b1;
    repeat (20) @(negedge clk);
    idle(10);
    check("short_no_frame", 32'(frames), 32'(f0));
    check("short_drop", 32'(drop_cnt), 32'd1);

    // Reset after digit 4 capture discards the partial frame
    for (int i = 0; i < 5; i++) show(i, pat(4'(i + 1)), 1'b0, 8);
    rst = 1'b1;
    idle(2);
    check("midrst_value", frame_value, 32'd0);
    check("midrst_valid", 32'(frame_valid), 32'd0);
    check("midrst_drop", 32'(drop_cnt), 32'd0);
    check("midrst_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    idle(4);
    f0 = frames;
    exp_q.push_back('{v: 32'h87654321, dp: 8'h00, bl: 8'h00, err: 1'b0});
    scan(32'h87654321, 8'h00, 8'h00, -1, 8);
    drain("post_rst_frame");
    check("post_rst_count", 32'(frames), 32'(f0 + 1));
    check("post_rst_drop", 32'(drop_cnt), 32'd0);

    idle(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter: STABLE_CYCLES, 4, consecutive identical synchronized samples required before a digit is captured; legal range 2..255.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 seg_h  input  7  active-low segment lines; bit0=a … bit6=g.
REQ-005 seg_dp  input  1  active-low decimal point.
REQ-006 seg_an  input  8  active-low digit enables; bit i low selects digit i.
REQ-007 frame_value  output  32  assembled frame; digit i at bits [4i+3:4i].
REQ-008 frame_dp  output  8  bit i = decimal point lit on digit i.
REQ-009 frame_blank  output  8  bit i = digit i had all segments off.
REQ-010 frame_err  output  1  at least one digit in the frame had an undecodable pattern.
REQ-011 frame_valid  output  1  one-cycle pulse; frame_* outputs updated this cycle.
REQ-012 drop_cnt  output  8  saturating count of frames aborted by out-of-order digits.

Function
REQ-013 seg_h, seg_dp and seg_an SHALL each pass through a 2-flop synchronizer before any other use.
REQ-014 Stability counter: increments when the synchronized 16-bit sample equals the previous cycle's sample, else clears to 0; saturates at STABLE_CYCLES-1.
REQ-015 Capture event: exactly one per stable window, in the cycle the counter first reaches STABLE_CYCLES-1, and only when seg_an has exactly one low bit; zero or multiple low bits give no capture.
REQ-016 Decode uses p = ~seg_h: 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9, 0x77→A, 0x7C→B, 0x39→C, 0x5E→D, 0x79→E, 0x71→F.
REQ-017 p = 0x00: nibble 0, blank bit set, no error; any other unlisted p: nibble 0, per-frame error flag set.
REQ-018 FSM states SYNC, COLLECT, EMIT; internal expect index 0..7.
REQ-019 SYNC: capture of digit 0 stores it, sets expect=1 and enters COLLECT; captures of digits 1..7 are ignored.
REQ-020 COLLECT: capture of digit==expect stores it; if expect==7 go EMIT, else expect+1.
REQ-021 COLLECT, capture of digit 0 with expect≠0: discard partial frame, store digit 0, expect=1, stay COLLECT; drop_cnt increments.
REQ-022 COLLECT, capture of any other digit≠expect: discard partial frame, go SYNC, drop_cnt increments (saturating at 255).
REQ-023 EMIT lasts one cycle: frame_valid=1, frame_value/frame_dp/frame_blank/frame_err load the assembled frame, next state SYNC; a capture in this cycle SHALL be handled with SYNC rules.
REQ-024 frame_valid asserts exactly one cycle after the digit-7 capture; latency input-stable→capture = 2 + STABLE_CYCLES-1 cycles.
REQ-025 frame_* outputs hold their values between EMIT cycles; the per-frame accumulators clear whenever a new frame starts at digit 0.

Reset
REQ-026 rst SHALL clear synchronizers, stability counter, accumulators, expect, drop_cnt and all outputs to 0, and force state SYNC.
REQ-027 rst asserted mid-frame SHALL discard the partial frame without pulsing frame_valid or incrementing drop_cnt.

Structure
REQ-028 Package seg7_pkg holds the 16 segment-pattern constants, blank pattern, NUM_DIGITS=8 and the FSM state enum.
REQ-029 Sub-module seg7_pat_decode: combinational p → {nibble, valid, blank}, instantiated once.

Verification
REQ-030 Scan digits 0..7 showing 1,2,3,4,5,6,7,8 (each held 8 cycles, STABLE_CYCLES=4) -> single frame_valid, frame_value=0x87654321, frame_err=0, frame_blank=0x00.
REQ-031 Digit 3 pattern p=0x01 (segment a only) -> frame_err=1, nibble 3 = 0, other digits correct.
REQ-032 Digit 5 blank (seg_h=0x7F), dp lit on digit 2 -> frame_blank=0x20, frame_dp=0x04.
REQ-033 Order 0,1,2,5 -> no frame_valid, drop_cnt=1; then full clean scan -> frame_valid with correct value.
REQ-034 Input held only STABLE_CYCLES-2 cycles per digit, or seg_an=0xFC -> no captures, no frame_valid.
REQ-035 rst pulse after digit 4 capture, then full scan -> outputs 0 during reset, one frame_valid afterwards, drop_cnt=0.
